iic_transaction_sequencer: RTL
==============================

IIC_TRANSACTION_SEQUENCER -- requirements
Module: iic_transaction_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: the maximum number of cycles allowed from command acceptance to i_cmd_done.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous to i_clk, active-high.
REQ-004 SHALL have port i_req_valid, input, 1 bit: transaction request.
REQ-005 SHALL have port o_req_ready, output, 1 bit: request accepted when this and i_req_valid are both high.
REQ-006 SHALL have port i_req_rw, input, 1 bit: 0 = register write, 1 = register read.
REQ-007 SHALL have port i_req_dev, input, 7 bits: 7-bit slave address.
REQ-008 SHALL have port i_req_reg, input, 8 bits: register address.
REQ-009 SHALL have port i_req_wdata, input, 8 bits: write data.
REQ-010 SHALL have port o_resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port o_resp_rdata, output, 8 bits: read data.
REQ-012 SHALL have port o_resp_err, output, 2 bits: 00 = ok, 01 = slave NACK, 10 = timeout.
REQ-013 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port o_cmd_valid, output, 1 bit: byte-engine command request.
REQ-015 SHALL have port i_cmd_ready, input, 1 bit: byte-engine command accept.
REQ-016 SHALL have port o_cmd, output, 3 bits: 000 START, 001 WRITE, 010 READ, 011 RESTART, 100 STOP.
REQ-017 SHALL have port o_cmd_byte, output, 8 bits: byte for WRITE; 0 otherwise.
REQ-018 SHALL have port o_cmd_nack, output, 1 bit: master ACK bit for READ (1 = NACK).
REQ-019 SHALL have port i_cmd_done, input, 1 bit: one-cycle pulse marking the end of the accepted command.
REQ-020 SHALL have port i_cmd_slv_nack, input, 1 bit: slave NACK status, valid with i_cmd_done after a WRITE.
REQ-021 SHALL have port i_cmd_rdata, input, 8 bits: received byte, valid with i_cmd_done after a READ.

Function
REQ-022 SHALL assert o_req_ready only in state IDLE while o_resp_valid is low; on acceptance it SHALL latch dev, reg, wdata and rw, then enter START.
REQ-023 SHALL sequence the states IDLE -> START -> DEV_W -> REG -> (rw=0: WDATA -> STOP | rw=1: RESTART -> DEV_R -> RDATA -> STOP) -> DONE -> IDLE.
REQ-024 SHALL issue exactly one command per non-IDLE, non-DONE state: START; WRITE {dev,1'b0}; WRITE reg; WRITE wdata; RESTART; WRITE {dev,1'b1}; READ with o_cmd_nack=1; STOP.
REQ-025 SHALL use a valid/ready command handshake: o_cmd_valid rises on state entry; o_cmd and o_cmd_byte stay stable while o_cmd_valid is high; o_cmd_valid drops on the cycle after i_cmd_valid&i_cmd_ready.
REQ-026 SHALL advance state on the cycle after i_cmd_done; i_cmd_done while no command is outstanding SHALL be ignored.
REQ-027 SHALL, when i_cmd_done arrives with i_cmd_slv_nack=1 after any WRITE, set the error to 01, skip the remaining bytes and go to STOP.
REQ-028 SHALL capture i_cmd_rdata into o_resp_rdata on i_cmd_done in RDATA; o_resp_rdata SHALL hold its value until the next read completes.
REQ-029 SHALL run a timeout counter that clears on each state entry and counts every cycle while waiting for ready or done; on reaching TIMEOUT_CYCLES-1 it SHALL set the error to 10 and go directly to DONE, with no STOP issued.
REQ-030 SHALL assert o_resp_valid for exactly one cycle in DONE, with o_resp_err valid in that cycle; o_resp_err SHALL hold until the next acceptance, where it clears to 00.
REQ-031 SHALL back-to-back the next request no earlier than the cycle after o_resp_valid.
REQ-032 SHALL latch a NACK on the STOP command itself, but SHALL NOT let it override an earlier error code.

Reset
REQ-033 SHALL, when i_rst is high at a clock edge, put the state in IDLE and drive o_cmd_valid, o_resp_valid, o_busy, o_resp_err, o_resp_rdata, o_cmd, o_cmd_byte, o_cmd_nack and the timeout counter to 0; o_req_ready SHALL be 1 from the first cycle after reset.
REQ-034 SHALL abandon any transaction in progress on reset mid-transaction, with no STOP and no o_resp_valid.

Verification
REQ-035 SHALL pass this scenario: write dev=0x50, reg=0x10, data=0xA5, with an always-ready engine and done 5 cycles after accept -> commands START, WRITE 0xA0, WRITE 0x10, WRITE 0xA5, STOP; then o_resp_valid with err=00.
REQ-036 SHALL pass this scenario: read dev=0x68, reg=0x75, with the engine returning 0x71 -> commands START, WRITE 0xD0, WRITE 0x75, RESTART, WRITE 0xD1, READ (nack=1), STOP; then rdata=0x71, err=00.
REQ-037 SHALL pass this scenario: slave NACK on the address byte in a write -> next command STOP; then err=01 and no REG/WDATA commands.
REQ-038 SHALL pass this scenario: TIMEOUT_CYCLES=16 with the engine never asserting done after REG accept -> o_resp_valid 16 cycles after accept, err=10, no STOP.
REQ-039 SHALL pass this scenario: ready held low for 3 cycles -> o_cmd and o_cmd_byte stable for all 3 cycles and exactly one accept.
REQ-040 SHALL pass this scenario: i_rst asserted during RDATA -> next cycle o_busy=0, o_cmd_valid=0, o_req_ready=1, and no o_resp_valid.

Source files
------------

// File: rtl/iic_transaction_sequencer.sv
// -----------------------------------------------------------------------------
// iic_transaction_sequencer
//
// Turns one register-level request (write reg / read reg on a 7-bit slave)
// into the ordered list of byte-engine commands for that transfer. It hands
// out one command at a time, waits for the engine to finish it, records slave
// NACKs and read data, and reports one response pulse per transaction.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_req_*           request: valid, rw (0 write / 1 read), dev, reg, wdata
//   o_req_ready       request accepted when high together with i_req_valid
//   o_resp_valid      one-cycle completion pulse
//   o_resp_rdata      last byte read; held until the next read completes
//   o_resp_err        00 ok, 01 slave NACK, 10 timeout; held until next accept
//   o_busy            high whenever the sequencer is not idle
//   o_cmd_valid/i_cmd_ready   command handshake towards the byte engine
//   o_cmd             000 START, 001 WRITE, 010 READ, 011 RESTART, 100 STOP
//   o_cmd_byte        byte to send for WRITE, 0 otherwise
//   o_cmd_nack        master ACK bit for READ (1 = NACK)
//   i_cmd_done        one-cycle end-of-command pulse from the engine
//   i_cmd_slv_nack    slave NACK, qualified by i_cmd_done
//   i_cmd_rdata       received byte, qualified by i_cmd_done
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a request
// S_START   | START condition
// S_DEV_W   | slave address with write bit
// S_REG     | register address byte
// S_WDATA   | write data byte
// S_RESTART | repeated START before the read phase
// S_DEV_R   | slave address with read bit
// S_RDATA   | read one byte, master NACKs it
// S_STOP    | STOP condition
// S_DONE    | one-cycle response pulse
// -----------------------------------------------------------------------------
module iic_transaction_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_rw,
    input  logic [6:0] i_req_dev,
    input  logic [7:0] i_req_reg,
    input  logic [7:0] i_req_wdata,
    output logic       o_resp_valid,
    output logic [7:0] o_resp_rdata,
    output logic [1:0] o_resp_err,
    output logic       o_busy,
    output logic       o_cmd_valid,
    input  logic       i_cmd_ready,
    output logic [2:0] o_cmd,
    output logic [7:0] o_cmd_byte,
    output logic       o_cmd_nack,
    input  logic       i_cmd_done,
    input  logic       i_cmd_slv_nack,
    input  logic [7:0] i_cmd_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WRITE   = 3'b001;
    localparam logic [2:0] CMD_READ    = 3'b010;
    localparam logic [2:0] CMD_RESTART = 3'b011;
    localparam logic [2:0] CMD_STOP    = 3'b100;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_DEV_W,
        S_REG,
        S_WDATA,
        S_RESTART,
        S_DEV_R,
        S_RDATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic             cmd_sent, sent_nxt;
    logic [CNT_W-1:0] to_cnt, cnt_nxt;
    logic [1:0]       err, err_nxt;
    logic [7:0]       rdata, rdata_nxt;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [7:0]       wdata_q;
    logic             rw_q;
    logic             load_req;
    logic             cmd_state;
    logic             is_write;
    logic             done_ok;

    // cmd_sent marks the current state's command as accepted and now
    // outstanding; valid is simply "command state and not yet accepted".
    assign cmd_state    = (state != S_IDLE) && (state != S_DONE);
    assign o_cmd_valid  = cmd_state && !cmd_sent;
    assign done_ok      = cmd_state && cmd_sent && i_cmd_done;
    assign o_busy       = (state != S_IDLE);
    assign o_resp_valid = (state == S_DONE);
    assign o_req_ready  = (state == S_IDLE) && !o_resp_valid;
    assign o_resp_err   = err;
    assign o_resp_rdata = rdata;
    assign is_write     = (state == S_DEV_W) || (state == S_REG) ||
                          (state == S_WDATA) || (state == S_DEV_R);

    always_comb begin
        o_cmd      = CMD_START;
        o_cmd_byte = 8'h00;
        o_cmd_nack = 1'b0;
        case (state)
            S_DEV_W: begin
                o_cmd      = CMD_WRITE;
                o_cmd_byte = {dev_q, 1'b0};
            end
            S_REG: begin
                o_cmd      = CMD_WRITE;
                o_cmd_byte = reg_q;
            end
            S_WDATA: begin
                o_cmd      = CMD_WRITE;
                o_cmd_byte = wdata_q;
            end
            S_RESTART: o_cmd = CMD_RESTART;
            S_DEV_R: begin
                o_cmd      = CMD_WRITE;
                o_cmd_byte = {dev_q, 1'b1};
            end
            S_RDATA: begin
                o_cmd      = CMD_READ;
                o_cmd_nack = 1'b1;
            end
            S_STOP:  o_cmd = CMD_STOP;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        sent_nxt  = cmd_sent;
        cnt_nxt   = to_cnt;
        err_nxt   = err;
        rdata_nxt = rdata;
        load_req  = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_req_valid && o_req_ready) begin
                    load_req  = 1'b1;
                    err_nxt   = ERR_OK;
                    state_nxt = S_START;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: begin
                if (o_cmd_valid && i_cmd_ready) begin
                    sent_nxt = 1'b1;
                end
                cnt_nxt = to_cnt + CNT_W'(1);
                // A completion landing on the last allowed cycle still counts.
                if (done_ok) begin
                    if (is_write && i_cmd_slv_nack) begin
                        err_nxt   = ERR_NACK;
                        state_nxt = S_STOP;
                    end else begin
                        case (state)
                            S_START:   state_nxt = S_DEV_W;
                            S_DEV_W:   state_nxt = S_REG;
                            S_REG:     state_nxt = rw_q ? S_RESTART : S_WDATA;
                            S_WDATA:   state_nxt = S_STOP;
                            S_RESTART: state_nxt = S_DEV_R;
                            S_DEV_R:   state_nxt = S_RDATA;
                            S_RDATA: begin
                                rdata_nxt = i_cmd_rdata;
                                state_nxt = S_STOP;
                            end
                            S_STOP: begin
                                // A NACK on STOP is reported only if nothing
                                // went wrong earlier in the transfer.
                                if (i_cmd_slv_nack && (err == ERR_OK)) begin
                                    err_nxt = ERR_NACK;
                                end
                                state_nxt = S_DONE;
                            end
                            default:   state_nxt = S_IDLE;
                        endcase
                    end
                end else if (to_cnt == CNT_LAST) begin
                    // Bus state is unknown after a stall, so no STOP is sent.
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = S_DONE;
                end
            end
        endcase

        if (state_nxt != state) begin
            cnt_nxt  = '0;
            sent_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cmd_sent <= 1'b0;
            to_cnt   <= '0;
            err      <= ERR_OK;
            rdata    <= 8'h00;
            dev_q    <= 7'h00;
            reg_q    <= 8'h00;
            wdata_q  <= 8'h00;
            rw_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd_sent <= sent_nxt;
            to_cnt   <= cnt_nxt;
            err      <= err_nxt;
            rdata    <= rdata_nxt;
            if (load_req) begin
                dev_q   <= i_req_dev;
                reg_q   <= i_req_reg;
                wdata_q <= i_req_wdata;
                rw_q    <= i_req_rw;
            end
        end
    end

endmodule
